mdu_unit: RTL and testbench

Multi-cycle multiply/divide unit for the pipelined MIPS core, in the EX stage beside the single-cycle ALU. It executes mult/multu/div/divu over several cycles, owns the HI/LO registers, and exposes a busy/stall handshake so the hazard unit can freeze issue of any HI/LO-touching instruction until results are committed.

---
 rtl/mdu_pkg.sv | 42 ++++
 rtl/mdu_div_iter.sv | 80 ++++++++
 rtl/mdu_unit.sv | 140 ++++++++++++++
 tb/tb_mdu_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, latency defaults and helpers for the multiply/divide unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mdu_pkg;

  // mdOp encodings driven by the EX stage
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  // Default busy latencies; the iterative divider always needs setup + 32 steps
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int ITER_DIV_CYCLES = 33;

  // Busy counter width; covers latencies up to 63 cycles
  localparam int CNT_W = 6;

  // HI/LO pair as one 64-bit word so a 64-bit product maps straight onto it
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // Ops that occupy the unit for several cycles (mult/multu/div/divu)
  function automatic logic is_long_op(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  // Two's-complement negate when n is set; used for magnitudes and sign fix-up
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// mdu_div_iter: radix-2 restoring divider on magnitudes; present only when MDU_ITER_DIV_EN is defined.
// Latency: setup on the start edge, 32 iteration edges, done held high for one cycle afterwards.
// Backpressure: none; a new start restarts it, the parent never starts it while busy.
`ifdef MDU_ITER_DIV_EN
module mdu_div_iter
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [1:0] {
    DV_IDLE = 2'd0,
    DV_ITER = 2'd1,
    DV_DONE = 2'd2
  } dv_state_e;

  dv_state_e   state;
  logic [4:0]  step;
  logic [31:0] dvs;
  logic [32:0] trial;
  logic        fits;
  logic [31:0] diff;

  // One restoring step: shift next dividend bit into the partial remainder and trial-subtract.
  // The partial remainder is always below the divisor, so the subtract result fits 32 bits.
  always_comb begin
    trial = {remainder, quotient[31]};
    fits  = trial >= {1'b0, dvs};
    diff  = trial[31:0] - dvs;
  end

  // Sequencer: capture magnitudes on start, run 32 steps, flag done for one cycle.
  // The quotient register doubles as the dividend shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= DV_IDLE;
      step      <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
    end else if (start) begin
      state     <= DV_ITER;
      step      <= '0;
      done      <= 1'b0;
      remainder <= '0;
      quotient  <= neg_if(dividend, is_signed & dividend[31]);
      dvs       <= neg_if(divisor, is_signed & divisor[31]);
    end else begin
      case (state)
        DV_ITER: begin
          quotient  <= {quotient[30:0], fits};
          remainder <= fits ? diff : trial[31:0];
          step      <= step + 5'd1;
          if (step == 5'd31) begin
            state <= DV_DONE;
            done  <= 1'b1;
          end
        end
        DV_DONE: begin
          done  <= 1'b0;
          state <= DV_IDLE;
        end
        default: begin
          state <= DV_IDLE;
        end
      endcase
    end
  end

endmodule
`endif

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle mult/multu/div/divu beside the EX-stage ALU; owns HI/LO. MDU_ITER_DIV_EN selects the iterative divider.
// Latency: MULT_CYCLES for multiplies, DIV_CYCLES for divides (33 with MDU_ITER_DIV_EN); mthi/mtlo write on the next edge.
// Backpressure: stall holds issue while busy or while a long op is being requested; starts seen while busy are dropped.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MULT_CYCLES);
`ifdef MDU_ITER_DIV_EN
  localparam logic [CNT_W-1:0] DIV_N = CNT_W'(ITER_DIV_CYCLES);
`else
  localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES);
`endif

  md_op_e           req_op;
  md_op_e           cur_op;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic             req_div;
  logic             last;
  logic             is_div;
  logic             is_sgn;
  logic             div_ready;
  logic             commit_ok;
  logic [63:0]      prod;
  logic [31:0]      q_mag;
  logic [31:0]      r_mag;
  hilo_t            mul_res;
  hilo_t            div_res;
  hilo_t            res;

  assign req_op  = md_op_e'(mdOp);
  assign req_div = (req_op == MD_DIV) | (req_op == MD_DIVU);
  assign stall   = busy | (start & is_long_op(mdOp));
  assign last    = busy & (cnt == CNT_W'(1));
  assign is_div  = (cur_op == MD_DIV) | (cur_op == MD_DIVU);
  assign is_sgn  = (cur_op == MD_MULT) | (cur_op == MD_DIV);

  // 64-bit product: sign-extending both operands to 64 bits makes the low half of an
  // unsigned multiply equal to the two's-complement signed product.
  always_comb begin
    prod    = {{32{is_sgn & op_a[31]}}, op_a} * {{32{is_sgn & op_b[31]}}, op_b};
    mul_res = hilo_t'(prod);
  end

`ifdef MDU_ITER_DIV_EN
  logic div_done;

  mdu_div_iter u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start & ~busy & req_div),
    .is_signed (req_op == MD_DIV),
    .dividend  (A),
    .divisor   (B),
    .done      (div_done),
    .quotient  (q_mag),
    .remainder (r_mag)
  );

  assign div_ready = div_done;
`else
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;

  // Behavioural divide on magnitudes; avoids the signed-overflow case of a native
  // signed divide and keeps divide-by-zero out of the arithmetic (never committed).
  always_comb begin
    mag_a  = neg_if(op_a, is_sgn & op_a[31]);
    mag_b  = neg_if(op_b, is_sgn & op_b[31]);
    safe_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_mag  = mag_a / safe_b;
    r_mag  = mag_a % safe_b;
  end

  assign div_ready = 1'b1;
`endif

  // Sign fix-up and commit select: quotient negative when operand signs differ,
  // remainder takes the dividend's sign; divide by zero leaves HI/LO alone.
  always_comb begin
    div_res.lo = neg_if(q_mag, is_sgn & (op_a[31] ^ op_b[31]));
    div_res.hi = neg_if(r_mag, is_sgn & op_a[31]);
    res        = is_div ? div_res : mul_res;
    commit_ok  = is_div ? (div_ready & (op_b != 32'd0)) : 1'b1;
  end

  // Control and HI/LO: accept long ops only when idle, count down the busy window,
  // commit on its last cycle; mthi/mtlo write directly without going busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      cur_op <= MD_NONE;
      op_a   <= '0;
      op_b   <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (last) begin
        busy <= 1'b0;
        if (commit_ok) begin
          hi <= res.hi;
          lo <= res.lo;
        end
      end
    end else if (start) begin
      case (req_op)
        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
          busy   <= 1'b1;
          cur_op <= req_op;
          op_a   <= A;
          op_b   <= B;
          cnt    <= req_div ? DIV_N : MUL_N;
        end
        MD_MTHI: hi <= A;
        MD_MTLO: lo <= A;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vectors for mdu_unit with hand-computed HI/LO, busy counts and stall.
// Latency: checks MULT 5 and DIV 10 (33 with MDU_ITER_DIV_EN) busy cycles.
// Backpressure: exercises a start issued while busy, which must be dropped.
module tb_mdu_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  mdOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk = 0;
  int n_err = 0;
  int nb;

`ifdef MDU_ITER_DIV_EN
  localparam int DIV_N = 33;
`else
  localparam int DIV_N = 10;
`endif

  mdu_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .mdOp    (mdOp),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge: issues a long op, scrambles A/B after the start edge,
  // counts busy cycles and returns at the negedge of the first idle cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy);
    start = 1'b1; mdOp = op; A = a; B = b;
    #1 chk("stall_start", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; mdOp = 3'd0; A = $urandom; B = $urandom;
    nbusy = 0;
    @(negedge clk);
    while (busy && nbusy < 200) begin
      nbusy++;
      @(negedge clk);
    end
    chk("stall_commit", {31'd0, stall}, 32'd0);
  endtask

  // Called at a negedge: mthi/mtlo, which must never raise stall or busy.
  task automatic move_to(input logic [2:0] op, input logic [31:0] v);
    start = 1'b1; mdOp = op; A = v; B = 32'd0;
    #1 chk("stall_mt", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; mdOp = 3'd0;
    @(negedge clk);
    chk("busy_mt", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; mdOp = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of a multiply
    move_to(MD_MTHI, 32'h0000_00AA);
    move_to(MD_MTLO, 32'h0000_00BB);
    chk("mthi_val", hi, 32'h0000_00AA);
    chk("mtlo_val", lo, 32'h0000_00BB);
    start = 1'b1; mdOp = MD_MULT; A = 32'd7; B = 32'd6;
    @(posedge clk); #1;
    start = 1'b0; mdOp = 3'd0;
    @(negedge clk);
    @(negedge clk);
    chk("busy_cycle2", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("no_late_commit_lo", lo, 32'd0);
    chk("no_late_commit_busy", {31'd0, busy}, 32'd0);

    // Signed and unsigned multiply of the same operands
    run_op(MD_MULT, 32'hFFFF_FFFF, 32'd2, nb);
    chk("mult_busy", nb, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, nb);
    chk("multu_busy", nb, 32'd5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // Divides: truncation toward zero, remainder follows the dividend
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, nb);
    chk("div_busy", nb, DIV_N);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    run_op(MD_DIVU, 32'd7, 32'd2, nb);
    chk("divu_busy", nb, DIV_N);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    // Overflow case and divide by zero
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);
    move_to(MD_MTHI, 32'h0000_0011);
    move_to(MD_MTLO, 32'h0000_0022);
    run_op(MD_DIV, 32'd5, 32'd0, nb);
    chk("dz_busy", nb, DIV_N);
    chk("dz_hi", hi, 32'h0000_0011);
    chk("dz_lo", lo, 32'h0000_0022);

    // Reserved op is a no-op
    start = 1'b1; mdOp = MD_RSVD; A = 32'h0000_DEAD; B = 32'd1;
    #1 chk("rsvd_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; mdOp = 3'd0;
    @(negedge clk);
    chk("rsvd_busy", {31'd0, busy}, 32'd0);
    chk("rsvd_hi", hi, 32'h0000_0011);
    chk("rsvd_lo", lo, 32'h0000_0022);

    // Start while busy is ignored
    start = 1'b1; mdOp = MD_MULT; A = 32'd3; B = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; mdOp = 3'd0;
    @(negedge clk);
    chk("busy_cycle1", {31'd0, busy}, 32'd1);
    nb = 1;
    start = 1'b1; mdOp = MD_DIVU; A = 32'd9; B = 32'd3;
    #1 chk("stall_while_busy", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; mdOp = 3'd0;
    @(negedge clk);
    while (busy && nb < 200) begin
      nb++;
      @(negedge clk);
    end
    chk("ign_busy", nb, 32'd5);
    chk("ign_lo", lo, 32'd9);
    chk("ign_hi", hi, 32'd0);
    repeat (DIV_N + 2) @(negedge clk);
    chk("ign_no_div_lo", lo, 32'd9);

    // Back-to-back: second multiply issued in the first idle cycle
    run_op(MD_MULT, 32'd2, 32'd3, nb);
    chk("b2b_first_lo", lo, 32'd6);
    run_op(MD_MULT, 32'd4, 32'd5, nb);
    chk("b2b_busy", nb, 32'd5);
    chk("b2b_lo", lo, 32'd20);
    chk("b2b_hi", hi, 32'd0);
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd4, nb);
    chk("neg_mult_lo", lo, 32'hFFFF_FFF4);
    chk("neg_mult_hi", hi, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
